buart_param: RTL

Parametrised full-duplex UART; next generation of the fixed 8N1 buart.
- Configurable at elaboration: clock/baud, data width, parity and stop bits.
- RX path: centre-sampled with start-bit glitch rejection, an RX FIFO, and sticky error flags.
- Sits between the CPU I/O register decode and the board serial pins.

---
 rtl/buart_pkg.sv | 22 ++
 rtl/baud_div.sv | 27 ++
 rtl/buart_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/buart_pkg.sv
// Shared constants and types for the parametrised UART.
package buart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_div.sv
// Free-running divider: tick for one cycle every LIM+1 clocks, restartable.
module baud_div #(
  parameter int unsigned LIM = 31
) (
  input  logic clk,
  input  logic resetq,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (LIM > 0) ? $clog2(LIM + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(LIM));

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/buart_param.sv
// Parametrised full-duplex UART: TX shifter, centre-sampled RX, FWFT RX FIFO
// and sticky line-error flags.
module buart_param
  import buart_pkg::*;
#(
  parameter int unsigned CLKFREQ   = 30000000,
  parameter int unsigned BAUD      = 921600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        resetq,
  input  logic                        rx,
  output logic                        tx,
  input  logic                        wr,
  input  logic [7:0]                  tx_data,
  output logic                        busy,
  input  logic                        rd,
  output logic                        valid,
  output logic [7:0]                  rx_data,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  input  logic                        clr_err
);

  localparam int unsigned BIT_LIM  = CLKFREQ / BAUD - 1;
  localparam int unsigned HALF_LIM = CLKFREQ / (2 * BAUD) - 1;
  localparam int unsigned NBITS    = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int unsigned AW       = $clog2(RX_DEPTH);
  localparam logic [AW:0] DEPTH_C  = RX_DEPTH[AW:0];

  // ---------------- TX ----------------
  logic        tx_q, busy_q, tx_tick, tx_start, tx_par;
  logic [10:0] tx_frame_d, tx_sh_q;
  logic [3:0]  tx_left_q;

  assign tx_start = wr && !busy_q;

  baud_div #(.LIM(BIT_LIM)) u_tx_div (
    .clk     (clk),
    .resetq  (resetq),
    .restart (tx_start),
    .tick    (tx_tick)
  );

  // Bits following the start bit, LSB first; unused upper positions are stop ones.
  always_comb begin
    tx_frame_d = '1;
    tx_par     = 1'b0;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      tx_frame_d[i] = tx_data[i];
      tx_par        = tx_par ^ tx_data[i];
    end
    if (PARITY == PAR_ODD) tx_par = ~tx_par;
    if (PARITY != PAR_NONE) tx_frame_d[DATA_BITS] = tx_par;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_sh_q   <= '1;
      tx_left_q <= '0;
    end else if (tx_start) begin
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
      tx_sh_q   <= tx_frame_d;
      tx_left_q <= 4'(NBITS - 1);
    end else if (busy_q && tx_tick) begin
      if (tx_left_q == '0) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        tx_q      <= tx_sh_q[0];
        tx_sh_q   <= {1'b1, tx_sh_q[10:1]};
        tx_left_q <= tx_left_q - 1'b1;
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

  // ---------------- RX ----------------
  rx_state_t            rx_st_q;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev_q, rx_fall, rx_restart, rx_tick;
  logic                 phase_q, rx_par_q, par_bad;
  logic [3:0]           bitidx_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 push_q, fe_q, pe_q;
  logic [7:0]           push_data_q;

  assign rx_s       = sync_q[1];
  assign rx_fall    = rx_prev_q && !rx_s;
  assign rx_restart = (rx_st_q == RX_IDLE) && rx_fall;

  baud_div #(.LIM(HALF_LIM)) u_rx_div (
    .clk     (clk),
    .resetq  (resetq),
    .restart (rx_restart),
    .tick    (rx_tick)
  );

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == PAR_EVEN) par_bad = (^rx_sh_q) ^ rx_par_q;
    if (PARITY == PAR_ODD)  par_bad = ~((^rx_sh_q) ^ rx_par_q);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // Half-bit ticks alternate edge/centre; phase_q marks the centre tick.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_st_q     <= RX_IDLE;
      phase_q     <= 1'b0;
      bitidx_q    <= '0;
      rx_sh_q     <= '0;
      rx_par_q    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      fe_q        <= 1'b0;
      pe_q        <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (clr_err) begin
        fe_q <= 1'b0;
        pe_q <= 1'b0;
      end
      case (rx_st_q)
        RX_IDLE: if (rx_fall) rx_st_q <= RX_START;
        RX_START: begin
          if (rx_tick) begin
            if (rx_s) begin
              rx_st_q <= RX_IDLE;
            end else begin
              rx_st_q  <= RX_DATA;
              phase_q  <= 1'b0;
              bitidx_q <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              rx_sh_q  <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
              bitidx_q <= bitidx_q + 1'b1;
              if (bitidx_q == 4'(DATA_BITS - 1))
                rx_st_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              rx_par_q <= rx_s;
              rx_st_q  <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              rx_st_q <= RX_IDLE;
              if (!rx_s) begin
                fe_q <= 1'b1;
              end else if (par_bad) begin
                pe_q <= 1'b1;
              end else begin
                push_q      <= 1'b1;
                push_data_q <= 8'(rx_sh_q);
              end
            end
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          ov_q, full, empty, pop, do_push;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign pop     = rd && !empty;
  assign do_push = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (clr_err) ov_q <= 1'b0;
      if (push_q && full && !pop) ov_q <= 1'b1;
    end
  end

  assign valid      = !empty;
  assign rx_data    = empty ? '0 : mem_q[rp_q];
  assign rx_count   = cnt_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

endmodule
